audio_frame_feeder: RTL and testbench

AUDIO_FRAME_FEEDER -- requirements
Module: audio_frame_feeder

---
 rtl/audio_pkg.sv | 21 ++
 rtl/sample_fifo.sv | 63 ++++++
 rtl/audio_frame_feeder.sv | 119 +++++++++++
 tb/tb_audio_frame_feeder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared widths, depths and state types for the audio frame feeder
package audio_pkg;

    // Default bits per channel sample.
    localparam int SAMPLE_W_DEF = 16;

    // A stereo pair is stored as one word: left in the upper half, right in the lower half.
    localparam int PAIR_W_DEF = 2 * SAMPLE_W_DEF;

    // Default stereo-pair FIFO depth (power of two).
    localparam int DEPTH_DEF = 8;

    // Post-reset disarm sequence of the LR edge detector: three blind cycles, then live.
    typedef enum logic [1:0] {
        ARM_W0   = 2'd0,
        ARM_W1   = 2'd1,
        ARM_W2   = 2'd2,
        ARM_LIVE = 2'd3
    } arm_state_t;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - stereo-pair FIFO with occupancy level and wrapping pointers
module sample_fifo
    import audio_pkg::*;
#(
    parameter int WIDTH = PAIR_W_DEF,
    parameter int DEPTH = DEPTH_DEF
)
(
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow locally so the storage is safe on its own.
    assign do_push = push && (level != LVL_FULL);
    assign do_pop  = pop  && (level != '0);

    // Head of queue is always visible; the consumer samples it when it pops.
    assign rd_data = mem[rd_ptr];

    // Storage array is not reset; validity is tracked by level alone.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; level tracks occupancy.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/audio_frame_feeder.sv
// rtl/audio_frame_feeder.sv - feeds buffered stereo pairs to the codec on each LR frame start
module audio_frame_feeder
    import audio_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int SAMPLE_W = SAMPLE_W_DEF
)
(
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [SAMPLE_W-1:0]      in_left,
    input  logic [SAMPLE_W-1:0]      in_right,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     daclrc,
    input  logic                     clr_underrun,
    output logic [SAMPLE_W-1:0]      data_left,
    output logic [SAMPLE_W-1:0]      data_right,
    output logic                     frame_strobe,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PAIR_W = 2 * SAMPLE_W;
    localparam int LVL_W  = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic              daclrc_s1;
    logic              daclrc_s2;
    logic              daclrc_d;
    arm_state_t        arm_state;
    logic              frame_start;
    logic              fifo_push;
    logic              fifo_pop;
    logic [PAIR_W-1:0] fifo_rd;
    logic [LVL_W-1:0]  fifo_level;

    assign level     = fifo_level;
    // Ready depends only on the registered level, so a same-cycle pop never opens it early.
    assign in_ready  = RST && (fifo_level != LVL_FULL);
    assign fifo_push = in_valid && in_ready;
    assign fifo_pop  = frame_start && (fifo_level != '0);

    sample_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .push    (fifo_push),
        .wr_data ({in_left, in_right}),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .level   (fifo_level)
    );

    // Two-flop synchronizer for the codec LR clock plus a delayed copy for edge detection.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            daclrc_s1 <= 1'b0;
            daclrc_s2 <= 1'b0;
            daclrc_d  <= 1'b0;
        end else begin
            daclrc_s1 <= daclrc;
            daclrc_s2 <= daclrc_s1;
            daclrc_d  <= daclrc_s2;
        end
    end

    // Keep the edge detector blind for the first three cycles after reset release.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            arm_state <= ARM_W0;
        end else begin
            case (arm_state)
                ARM_W0:  arm_state <= ARM_W1;
                ARM_W1:  arm_state <= ARM_W2;
                ARM_W2:  arm_state <= ARM_LIVE;
                default: arm_state <= ARM_LIVE;
            endcase
        end
    end

    // Registered falling-edge detect: a falling LR edge marks the start of a left channel.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= (arm_state == ARM_LIVE) && daclrc_d && !daclrc_s2;
        end
    end

    // Load the head pair on frame start; outputs hold their value across an empty frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_left    <= '0;
            data_right   <= '0;
            frame_strobe <= 1'b0;
        end else begin
            frame_strobe <= frame_start;
            if (fifo_pop) begin
                data_left  <= fifo_rd[PAIR_W-1:SAMPLE_W];
                data_right <= fifo_rd[SAMPLE_W-1:0];
            end
        end
    end

    // Sticky underrun: a new empty frame start wins over a simultaneous clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            underrun <= 1'b0;
        end else if (frame_start && (fifo_level == '0)) begin
            underrun <= 1'b1;
        end else if (clr_underrun) begin
            underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_audio_frame_feeder.sv
// tb/tb_audio_frame_feeder.sv - directed self-checking bench for audio_frame_feeder
module tb_audio_frame_feeder;

    logic        CLK;
    logic        RST;
    logic [15:0] in_left;
    logic [15:0] in_right;
    logic        in_valid;
    logic        in_ready;
    logic        daclrc;
    logic        clr_underrun;
    logic [15:0] data_left;
    logic [15:0] data_right;
    logic        frame_strobe;
    logic        underrun;
    logic [3:0]  level;

    int n_cmp = 0;
    int n_err = 0;
    int max_lvl = 0;
    bit mon_en = 1'b0;

    audio_frame_feeder #(
        .DEPTH    (8),
        .SAMPLE_W (16)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .in_left      (in_left),
        .in_right     (in_right),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .daclrc       (daclrc),
        .clr_underrun (clr_underrun),
        .data_left    (data_left),
        .data_right   (data_right),
        .frame_strobe (frame_strobe),
        .underrun     (underrun),
        .level        (level)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (mon_en && (int'(level) > max_lvl)) max_lvl = int'(level);
    end

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r, output bit acc);
        in_left  = l;
        in_right = r;
        in_valid = 1'b1;
        @(negedge CLK);
        acc = in_ready;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    // Rising LR edge, then a falling one; data captured 4 cycles after the fall, strobes counted throughout.
    task automatic do_frame(input bit clr_coincide, output int strobes, output logic [31:0] data4);
        strobes = 0;
        daclrc  = 1'b1;
        repeat (6) begin
            @(posedge CLK);
            #1;
            if (frame_strobe) strobes++;
        end
        daclrc = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (clr_coincide && k == 4) clr_underrun = 1'b1;
            @(posedge CLK);
            #1;
            clr_underrun = 1'b0;
            if (frame_strobe) strobes++;
        end
        data4 = {data_left, data_right};
        repeat (4) begin
            @(posedge CLK);
            #1;
            if (frame_strobe) strobes++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc;
        int          n_acc;
        int          st;
        logic [31:0] d4;

        RST          = 1'b0;
        in_left      = '0;
        in_right     = '0;
        in_valid     = 1'b0;
        daclrc       = 1'b0;
        clr_underrun = 1'b0;

        tick(3);
        expect_eq("rst_in_ready", in_ready, 0);
        expect_eq("rst_level", level, 0);
        expect_eq("rst_data", {data_left, data_right}, 0);
        expect_eq("rst_strobe", frame_strobe, 0);
        expect_eq("rst_underrun", underrun, 0);
        RST = 1'b1;
        tick(4);
        expect_eq("post_rst_ready", in_ready, 1);

        // Two pairs, two frames, in order.
        push_pair(16'h1111, 16'hAAAA, acc);
        push_pair(16'h2222, 16'hBBBB, acc);
        expect_eq("two_pair_level", level, 2);
        do_frame(1'b0, st, d4);
        expect_eq("frame1_data", d4, 32'h1111_AAAA);
        expect_eq("frame1_strobes", st, 1);
        tick(50);
        do_frame(1'b0, st, d4);
        expect_eq("frame2_data", d4, 32'h2222_BBBB);
        expect_eq("frame2_strobes", st, 1);
        expect_eq("frame2_level", level, 0);

        // Fill to full; ninth pair refused.
        n_acc = 0;
        for (int i = 0; i < 9; i++) begin
            push_pair(16'h3000 + 16'(i), 16'hC000 + 16'(i), acc);
            if (acc) n_acc++;
        end
        expect_eq("full_accepts", n_acc, 8);
        expect_eq("full_level", level, 8);
        expect_eq("full_in_ready", in_ready, 0);
        do_frame(1'b0, st, d4);
        expect_eq("full_pop_data", d4, 32'h3000_C000);
        expect_eq("full_pop_level", level, 7);
        expect_eq("full_pop_ready", in_ready, 1);
        for (int i = 1; i < 8; i++) begin
            do_frame(1'b0, st, d4);
            expect_eq($sformatf("drain_%0d", i), d4, {16'h3000 + 16'(i), 16'hC000 + 16'(i)});
        end
        expect_eq("drain_level", level, 0);
        expect_eq("no_underrun_yet", underrun, 0);

        // Underrun behaviour.
        push_pair(16'h1234, 16'h5678, acc);
        do_frame(1'b0, st, d4);
        expect_eq("pre_underrun_data", d4, 32'h1234_5678);
        do_frame(1'b0, st, d4);
        expect_eq("underrun_hold", d4, 32'h1234_5678);
        expect_eq("underrun_strobes", st, 1);
        expect_eq("underrun_set", underrun, 1);
        clr_underrun = 1'b1;
        tick(1);
        clr_underrun = 1'b0;
        tick(1);
        expect_eq("underrun_clr", underrun, 0);
        do_frame(1'b1, st, d4);
        expect_eq("underrun_coincide", underrun, 1);
        expect_eq("coincide_hold", d4, 32'h1234_5678);
        clr_underrun = 1'b1;
        tick(1);
        clr_underrun = 1'b0;

        // Twenty pairs streamed through, crossing the pointer wrap.
        max_lvl = 0;
        mon_en  = 1'b1;
        push_pair(16'h4000, 16'h8000, acc);
        for (int i = 1; i < 21; i++) begin
            if (i < 20) push_pair(16'h4000 + 16'(i), 16'h8000 + 16'(i), acc);
            do_frame(1'b0, st, d4);
            expect_eq($sformatf("stream_%0d", i - 1), d4, {16'h4000 + 16'(i - 1), 16'h8000 + 16'(i - 1)});
        end
        mon_en = 1'b0;
        expect_eq("stream_max_level_le2", (max_lvl <= 2), 1);
        expect_eq("stream_underrun", underrun, 0);

        // Asynchronous reset mid-operation.
        for (int i = 0; i < 5; i++) push_pair(16'h5000 + 16'(i), 16'h6000 + 16'(i), acc);
        expect_eq("pre_rst_level", level, 5);
        daclrc = 1'b1;
        tick(3);
        #3;
        RST = 1'b0;
        #1;
        expect_eq("async_rst_level", level, 0);
        expect_eq("async_rst_data", {data_left, data_right}, 0);
        expect_eq("async_rst_ready", in_ready, 0);
        daclrc = 1'b0;
        #7;
        daclrc = 1'b1;
        #7;
        daclrc = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        st = 0;
        repeat (10) begin
            @(posedge CLK);
            #1;
            if (frame_strobe) st++;
        end
        expect_eq("rel_no_strobe", st, 0);
        expect_eq("rel_level", level, 0);
        expect_eq("rel_underrun", underrun, 0);
        push_pair(16'hABCD, 16'hDCBA, acc);
        do_frame(1'b0, st, d4);
        expect_eq("rel_frame_data", d4, 32'hABCD_DCBA);
        expect_eq("rel_frame_strobes", st, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
